// File: rtl/ps2_keyboard_rx_if.sv
// Keyboard receiver <-> keyboard controller bus: FIFO pop handshake plus status pulses.
interface ps2_keyboard_rx_if;
  logic       rd;
  logic [7:0] data;
  logic       empty;
  logic       overflow;
  logic       err_parity;
  logic       err_frame;

  // Controller side: pops bytes and watches status
  modport master (
    output rd,
    input  data, empty, overflow, err_parity, err_frame
  );

  // Receiver side: presents FIFO head and status
  modport slave (
    input  rd,
    output data, empty, overflow, err_parity, err_frame
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin sync, clock deglitch, 11-bit frame deserialiser
// with start/odd-parity/stop checking, and a small FWFT byte FIFO.
module ps2_keyboard_rx #(
  parameter int FILTER    = 8,
  parameter int TIMEOUT   = 25000,
  parameter int FIFO_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  ps2_keyboard_rx_if.slave   bus
);

  localparam int FW    = $clog2(FILTER + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FW-1:0] FMAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_filt;
  logic [FW-1:0]   r_fcnt;
  logic            w_fall;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_bitcnt, w_bitcnt_nxt;
  logic [7:0]      r_sreg, w_sreg_nxt;
  logic            r_par, w_par_nxt;
  logic [TW-1:0]   r_tcnt, w_tcnt_nxt;
  logic            r_push, w_push_nxt;
  logic            r_err_p, w_err_p_nxt;
  logic            r_err_f, w_err_f_nxt;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_LOG2:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic [7:0]         r_data, w_head_nxt;
  logic               r_ovf;
  logic               w_empty, w_full, w_pop, w_wr;

  // Two-flop synchronisers on both pins, idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock deglitch: level follows only after FILTER consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s2 != r_filt) begin
      if (r_fcnt == FMAX) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end else begin
      r_fcnt <= '0;
    end
  end

  // Strobe on the cycle the filtered level is about to drop; dat sampled alongside
  assign w_fall = r_filt & ~r_clk_s2 & (r_fcnt == FMAX);

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_sreg   <= '0;
      r_par    <= 1'b0;
      r_tcnt   <= '0;
      r_push   <= 1'b0;
      r_err_p  <= 1'b0;
      r_err_f  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sreg   <= w_sreg_nxt;
      r_par    <= w_par_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_push   <= w_push_nxt;
      r_err_p  <= w_err_p_nxt;
      r_err_f  <= w_err_f_nxt;
    end
  end

  // Frame FSM next-state, timeout and result strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_sreg_nxt   = r_sreg;
    w_par_nxt    = r_par;
    w_tcnt_nxt   = r_tcnt;
    w_push_nxt   = 1'b0;
    w_err_p_nxt  = 1'b0;
    w_err_f_nxt  = 1'b0;

    if (r_state == S_IDLE || w_fall) begin
      w_tcnt_nxt = '0;
    end else if (r_tcnt == TMAX) begin
      w_tcnt_nxt  = '0;
      w_state_nxt = S_IDLE;
      w_err_f_nxt = 1'b1;
    end else begin
      w_tcnt_nxt = r_tcnt + 1'b1;
    end

    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = '0;
          end
        end
        S_DATA: begin
          w_sreg_nxt   = {r_dat_s2, r_sreg[7:1]};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          w_par_nxt   = r_dat_s2;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (!r_dat_s2)               w_err_f_nxt = 1'b1;
          else if (^{r_sreg, r_par})   w_push_nxt  = 1'b1;
          else                         w_err_p_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FIFO control; registered head tracks what the head will be after this cycle,
  // taking the incoming byte directly when it lands in the head slot
  always_comb begin
    w_empty    = (r_wptr == r_rptr);
    w_full     = (r_wptr[FIFO_LOG2] != r_rptr[FIFO_LOG2]) &&
                 (r_wptr[FIFO_LOG2-1:0] == r_rptr[FIFO_LOG2-1:0]);
    w_pop      = bus.rd & ~w_empty;
    w_wr       = r_push & (~w_full | w_pop);
    w_wptr_nxt = r_wptr + {{FIFO_LOG2{1'b0}}, w_wr};
    w_rptr_nxt = r_rptr + {{FIFO_LOG2{1'b0}}, w_pop};
    w_head_nxt = r_data;
    if (w_wptr_nxt != w_rptr_nxt) begin
      if (w_wr && (w_rptr_nxt == r_wptr)) w_head_nxt = r_sreg;
      else                                w_head_nxt = r_mem[w_rptr_nxt[FIFO_LOG2-1:0]];
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[FIFO_LOG2-1:0]] <= r_sreg;
  end

  // FIFO pointers, head register and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_data <= w_head_nxt;
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign bus.data       = r_data;
  assign bus.empty      = w_empty;
  assign bus.overflow   = r_ovf;
  assign bus.err_parity = r_err_p;
  assign bus.err_frame  = r_err_f;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames, models received bytes and errors
// as a queue plus counters, and compares every settled cycle.
module tb_ps2_keyboard_rx;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 600;
  localparam int HALF    = 40;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_keyboard_rx_if bus();

  ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_LOG2(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .bus     (bus)
  );

  always #20 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  int unsigned exp_perr = 0, exp_ferr = 0;
  int unsigned act_perr = 0, act_ferr = 0;
  logic       settled = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame outcome from the protocol rules: stop 0 beats everything, then odd parity
  task automatic apply_frame(input logic [7:0] b, input logic par, input logic stop);
    int ones;
    ones = par;
    for (int i = 0; i < 8; i++) ones += b[i];
    if (!stop)               exp_ferr++;
    else if (ones % 2 == 0)  exp_perr++;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else                     q.push_back(b);
  endtask

  // Sends the first nbits of {stop,par,b,start}; optional short low glitch in the high phase of bit glitch_at
  task automatic send(input logic [7:0] b, input logic par, input logic stop,
                      input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    settled = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = f[i];
      if (i == glitch_at) begin
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILTER - 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF / 2 - 5 - (FILTER - 2)) @(negedge clk);
      end else begin
        repeat (HALF / 2) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
    if (nbits == 11) apply_frame(b, par, stop);
    settled = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send(b, ~^b, 1'b1, 11, -1);
  endtask

  task automatic read_byte(input logic [7:0] exp_lit);
    @(negedge clk);
    check("read_head_literal", {24'd0, bus.data}, {24'd0, exp_lit});
    bus.rd = 1'b1;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  // Error pulse counters and mutual exclusion
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.err_parity) act_perr++;
      if (bus.err_frame)  act_ferr++;
      if (bus.err_parity && bus.err_frame) check("err_both", 32'd1, 32'd0);
    end
  end

  // Per-cycle comparison against the model while nothing is in flight
  always @(negedge clk) begin
    if (settled && !rst) begin
      check("empty", {31'd0, bus.empty}, {31'd0, q.size() == 0});
      if (q.size() != 0) check("data", {24'd0, bus.data}, {24'd0, q[0]});
      check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    end
  end

  task automatic check_errs(input string tag);
    check({tag, "_perr"}, act_perr, exp_perr);
    check({tag, "_ferr"}, act_ferr, exp_ferr);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus.rd = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_empty",    {31'd0, bus.empty},      32'd1);
    check("rst_data",     {24'd0, bus.data},       32'd0);
    check("rst_overflow", {31'd0, bus.overflow},   32'd0);
    check("rst_perr",     {31'd0, bus.err_parity}, 32'd0);
    check("rst_ferr",     {31'd0, bus.err_frame},  32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    settled = 1'b1;

    // 1: good 0x1C
    send_ok(8'h1C);
    check("t1_empty", {31'd0, bus.empty}, 32'd0);
    check("t1_data",  {24'd0, bus.data},  32'h1C);
    read_byte(8'h1C);
    @(negedge clk);
    check("t1_empty_after_rd", {31'd0, bus.empty}, 32'd1);

    // 2: 0x1C with wrong parity
    send(8'h1C, 1'b1, 1'b1, 11, -1);
    check("t2_perr_lit", act_perr, 32'd1);
    check("t2_ferr_lit", act_ferr, 32'd0);
    check_errs("t2");

    // 3: 0x5A with stop 0, then good 0xF0
    send(8'h5A, 1'b1, 1'b0, 11, -1);
    check("t3_ferr_lit", act_ferr, 32'd1);
    check("t3_empty", {31'd0, bus.empty}, 32'd1);
    send_ok(8'hF0);
    check("t3_data", {24'd0, bus.data}, 32'hF0);
    read_byte(8'hF0);
    check_errs("t3");

    // 4: start + 4 data bits then silence past the timeout, then 0xE0
    send(8'hA5, 1'b1, 1'b1, 5, -1);
    repeat (TIMEOUT + 200) @(negedge clk);
    exp_ferr++;
    check("t4_ferr_lit", act_ferr, 32'd2);
    check_errs("t4");
    send_ok(8'hE0);
    check("t4_data", {24'd0, bus.data}, 32'hE0);
    read_byte(8'hE0);

    // 5: five frames without reading
    for (int i = 1; i <= 5; i++) send_ok(8'(i));
    check("t5_overflow", {31'd0, bus.overflow}, 32'd1);
    for (int i = 1; i <= 4; i++) read_byte(8'(i));
    @(negedge clk);
    check("t5_empty", {31'd0, bus.empty}, 32'd1);
    check_errs("t5");

    // 6: glitches in idle and mid-frame, then reset mid-frame
    settled = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER - 2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    settled = 1'b1;
    check_errs("t6_idle_glitch");
    send(8'h29, 1'b0, 1'b1, 11, 4);
    check("t6_data", {24'd0, bus.data}, 32'h29);
    check_errs("t6_mid_glitch");
    send(8'h29, 1'b0, 1'b1, 4, -1);
    settled = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    m_ovf = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_empty", {31'd0, bus.empty},    32'd1);
    check("t6_rst_ovf",   {31'd0, bus.overflow}, 32'd0);
    repeat (20) @(negedge clk);
    settled = 1'b1;
    send_ok(8'h29);
    check("t6_after_rst_data", {24'd0, bus.data}, 32'h29);
    read_byte(8'h29);
    check_errs("t6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
